// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control logic.
//   REG_ID_W    : register specifier width (16 architectural registers)
//   pipe_state_e: pipeline sequencer state encoding
//   pipe_ctrl_t : bundle of pipeline-register enables and NOP-insertion controls
package core_pkg;

    localparam int REG_ID_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FLOW   = 5'b11000;
    localparam pipe_ctrl_t CTRL_FREEZE = 5'b00001;
    localparam pipe_ctrl_t CTRL_STALL  = 5'b00010;
    localparam pipe_ctrl_t CTRL_FLUSH  = 5'b11110;
    localparam pipe_ctrl_t CTRL_HOLD   = 5'b00000;

endpackage

// File: rtl/ctrl_load_use_cmp.sv
// Load-use hazard comparator.
// Flags the case where the instruction in EX is a load whose destination
// matches a source register actually read by the instruction in ID.
// Ports:
//   rs, rt           : ID-stage source register specifiers
//   uses_rs, uses_rt : ID instruction reads rs / rt
//   ex_rt            : destination of the EX-stage instruction
//   ex_mem_read      : EX-stage instruction is a load
//   luse             : load-use hazard present
module ctrl_load_use_cmp
    import core_pkg::*;
(
    input  logic [REG_ID_W-1:0] rs,
    input  logic [REG_ID_W-1:0] rt,
    input  logic                uses_rs,
    input  logic                uses_rt,
    input  logic [REG_ID_W-1:0] ex_rt,
    input  logic                ex_mem_read,
    output logic                luse
);

    assign luse = ex_mem_read & ((uses_rs & (ex_rt == rs)) | (uses_rt & (ex_rt == rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Merges load-use stalls, taken-branch flushes, data-memory wait freezes and
// HLT draining into one prioritised set of pipeline-register controls, and
// owns the halted / memory-timeout status.
//
// Ports:
//   clk, rst_n          : core clock, asynchronous active-low reset
//   if_id_*             : ID-stage source specifiers and use flags
//   id_ex_rt/mem_read   : EX-stage destination and load flag
//   ex_branch_taken     : EX resolved a taken branch/jump
//   id_halt             : ID holds HLT
//   mem_req, mem_ready  : MEM-stage data memory handshake
//   pc_write .. pipe_freeze : pipeline register controls
//   halted, mem_err     : status (mem_err sticky until reset)
//   stall_cycles        : stall/freeze cycle counter
//
// Build option: PIPE_CTRL_PERF_EN enables the saturating stall counter;
// otherwise stall_cycles is tied to zero.
//
// state  | meaning
// RUN    | normal flow, hazards resolved per cycle
// DRAIN  | HLT passed ID; older instructions retiring, front end held
// HALTED | core stopped (drain complete or memory timeout); reset only exit
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_ID_W-1:0] if_id_rs,
    input  logic [REG_ID_W-1:0] if_id_rt,
    input  logic                if_id_uses_rs,
    input  logic                if_id_uses_rt,
    input  logic [REG_ID_W-1:0] id_ex_rt,
    input  logic                id_ex_mem_read,
    input  logic                ex_branch_taken,
    input  logic                id_halt,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                id_ex_bubble,
    output logic                pipe_freeze,
    output logic                halted,
    output logic                mem_err,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    pipe_state_e        state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic               err_nxt;
    pipe_ctrl_t         ctrl;
    logic               luse;
    logic               mwait;

    ctrl_load_use_cmp u_luse (
        .rs          (if_id_rs),
        .rt          (if_id_rt),
        .uses_rs     (if_id_uses_rs),
        .uses_rt     (if_id_uses_rt),
        .ex_rt       (id_ex_rt),
        .ex_mem_read (id_ex_mem_read),
        .luse        (luse)
    );

    assign mwait = mem_req & ~mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            wait_cnt  <= wait_nxt;
            mem_err   <= err_nxt;
        end
    end

    always_comb begin
        ctrl      = CTRL_FLOW;
        state_nxt = state;
        drain_nxt = drain_cnt;
        wait_nxt  = '0;
        err_nxt   = mem_err;
        case (state)
            RUN, DRAIN: begin
                if (mwait) begin
                    // Memory wait overrides everything; DRAIN progress holds.
                    ctrl     = CTRL_FREEZE;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALTED;
                    end
                end else if (state == DRAIN) begin
                    ctrl = CTRL_STALL;
                    if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_nxt = HALTED;
                    end else begin
                        drain_nxt = drain_cnt + DRAIN_W'(1);
                    end
                end else if (ex_branch_taken) begin
                    // ID instruction is squashed, so its hazards and HLT are moot.
                    ctrl = CTRL_FLUSH;
                end else if (luse) begin
                    ctrl = CTRL_STALL;
                end else if (id_halt) begin
                    // HLT itself advances into EX; the front end stops here.
                    ctrl      = CTRL_HOLD;
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end
            end
            default: begin
                ctrl     = CTRL_FREEZE;
                wait_nxt = wait_cnt;
            end
        endcase
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign pipe_freeze  = ctrl.pipe_freeze;
    assign halted       = (state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state != HALTED) && !ctrl.pc_write && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int CNT_W = 16;

    // Expected flag vector: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
    //                        pipe_freeze, halted, mem_err}
    localparam logic [6:0] E_RUN  = 7'b1100000;
    localparam logic [6:0] E_STL  = 7'b0001000;
    localparam logic [6:0] E_BR   = 7'b1111000;
    localparam logic [6:0] E_FRZ  = 7'b0000100;
    localparam logic [6:0] E_HLT  = 7'b0000000;
    localparam logic [6:0] E_HALT = 7'b0000110;
    localparam logic [6:0] E_TERR = 7'b0000111;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]       flags;
        logic [CNT_W-1:0] stall;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       if_id_rs, if_id_rt, id_ex_rt;
    logic             if_id_uses_rs, if_id_uses_rt, id_ex_mem_read;
    logic             ex_branch_taken, id_halt, mem_req, mem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic             pipe_freeze, halted, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    exp_t             exp_q[$];
    string            nm_q[$];
    int               total = 0;
    int               bad = 0;
    int               exp_stall = 0;

    pipe_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_uses_rs   (if_id_uses_rs),
        .if_id_uses_rt   (if_id_uses_rt),
        .id_ex_rt        (id_ex_rt),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .id_halt         (id_halt),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_freeze     (pipe_freeze),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents a full control word every cycle; check it
    // mid-cycle against whatever the stimulus queued for that cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            string      nm;
            logic [6:0] got;
            e   = exp_q.pop_front();
            nm  = nm_q.pop_front();
            got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted, mem_err};
            total++;
            if (got !== e.flags || stall_cycles !== e.stall) begin
                bad++;
                $display("FAIL %s: got flags=%b stall=%0d, want flags=%b stall=%0d",
                         nm, got, stall_cycles, e.flags, e.stall);
            end
        end
    end

    task automatic idle_inputs();
        if_id_rs = 4'd0; if_id_rt = 4'd0; id_ex_rt = 4'd0;
        if_id_uses_rs = 1'b0; if_id_uses_rt = 1'b0; id_ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; id_halt = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Queue the expectation for the current cycle, advance the stall model,
    // then move to just after the next rising edge.
    task automatic cyc(input string nm, input logic [6:0] e);
        exp_t x;
        x.flags = e;
        x.stall = PERF ? CNT_W'(exp_stall) : '0;
        exp_q.push_back(x);
        nm_q.push_back(nm);
        if (!e[6] && !e[1]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        exp_stall = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        cyc("reset_state", E_RUN);

        // Load-use on rs, then released.
        id_ex_mem_read = 1'b1; id_ex_rt = 4'd5; if_id_rs = 4'd5; if_id_uses_rs = 1'b1;
        cyc("luse_rs", E_STL);
        id_ex_mem_read = 1'b0;
        cyc("luse_released", E_RUN);
        // Matching register but not read -> no stall.
        id_ex_mem_read = 1'b1; if_id_uses_rs = 1'b0;
        cyc("luse_unused_rs", E_RUN);
        // Load-use on rt.
        if_id_rs = 4'd3; if_id_rt = 4'd5; if_id_uses_rt = 1'b1;
        cyc("luse_rt", E_STL);
        // Branch beats load-use; no stall counted.
        ex_branch_taken = 1'b1;
        cyc("branch_over_luse", E_BR);
        idle_inputs();
        cyc("post_branch", E_RUN);

        // Four-cycle memory wait with a branch pulse in cycle 2.
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mwait_1", E_FRZ);
        ex_branch_taken = 1'b1;
        cyc("mwait_2_branch", E_FRZ);
        ex_branch_taken = 1'b0;
        cyc("mwait_3", E_FRZ);
        cyc("mwait_4", E_FRZ);
        mem_ready = 1'b1;
        cyc("mwait_release", E_RUN);
        idle_inputs();

        // HLT then async reset in the middle of DRAIN.
        id_halt = 1'b1;
        cyc("hlt_issue_a", E_HLT);
        id_halt = 1'b0;
        cyc("drain_a0", E_STL);
        rst_n = 1'b0;
        exp_stall = 0;
        cyc("async_reset_drain", E_RUN);
        rst_n = 1'b1;
        cyc("after_reset", E_RUN);

        // Plain HLT: halted after three drain cycles.
        id_halt = 1'b1;
        cyc("hlt_issue_b", E_HLT);
        id_halt = 1'b0;
        cyc("drain_b0", E_STL);
        cyc("drain_b1", E_STL);
        cyc("drain_b2", E_STL);
        cyc("halted_b", E_HALT);
        cyc("halted_b_hold", E_HALT);

        // HLT with a two-cycle memory wait inside DRAIN.
        do_reset();
        id_halt = 1'b1;
        cyc("hlt_issue_c", E_HLT);
        id_halt = 1'b0;
        cyc("drain_c0", E_STL);
        mem_req = 1'b1;
        cyc("drain_c_frz1", E_FRZ);
        cyc("drain_c_frz2", E_FRZ);
        mem_req = 1'b0;
        cyc("drain_c1", E_STL);
        cyc("drain_c2", E_STL);
        cyc("halted_c", E_HALT);

        // Memory timeout: 15 frozen cycles, then error halt.
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc("timeout_wait", E_FRZ);
        cyc("timeout_halt", E_TERR);
        mem_ready = 1'b1;
        cyc("timeout_sticky", E_TERR);
        idle_inputs();
        id_halt = 1'b1; ex_branch_taken = 1'b1;
        cyc("timeout_ignore_inputs", E_TERR);

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
